// File: rtl/dl_shift_arb.sv
// rtl/dl_shift_arb.sv - round-robin arbiter sharing one barrel shifter among NUM_REQ requesters
// Optional feature macro: DL_SHIFT_ARB_STALL_CNT_EN (adds the saturating stall_cnt output)
module dl_shift_arb #(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_BITS = 32,
  localparam int ID_BITS  = $clog2(NUM_REQ),
  localparam int SH_BITS  = $clog2(NUM_BITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_data,
  input  logic [NUM_REQ*SH_BITS-1:0]  req_shamt,
  input  logic [NUM_REQ*2-1:0]        req_op,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [NUM_BITS-1:0]         resp_data,
  output logic [ID_BITS-1:0]          resp_id
`ifdef DL_SHIFT_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ID_BITS-1:0]   ptr_q;
  logic [ID_BITS-1:0]   gnt;
  logic                 gnt_vld;
  logic                 can_accept;
  logic                 accept;
  logic [NUM_BITS-1:0]  op_data  [NUM_REQ];
  logic [SH_BITS-1:0]   op_shamt [NUM_REQ];
  logic [1:0]           op_code  [NUM_REQ];
  logic [NUM_BITS-1:0]  shift_res;

  // Barrel shifter; ROR takes the low half of the doubled operand shifted right
  function automatic logic [NUM_BITS-1:0] do_shift(input logic [NUM_BITS-1:0] d,
                                                   input logic [SH_BITS-1:0]  s,
                                                   input logic [1:0]          op);
    logic [2*NUM_BITS-1:0] rot;
    logic [NUM_BITS-1:0]   res;
    rot = {d, d} >> s;
    case (op)
      2'b00:   res = d << s;
      2'b01:   res = d >> s;
      2'b10:   res = $signed(d) >>> s;
      default: res = rot[NUM_BITS-1:0];
    endcase
    return res;
  endfunction

  // Unpack the flat request buses into per-requester fields
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_data[i]  = req_data[i*NUM_BITS +: NUM_BITS];
      op_shamt[i] = req_shamt[i*SH_BITS +: SH_BITS];
      op_code[i]  = req_op[i*2 +: 2];
    end
  end

  // Round-robin scan starting at ptr_q; first valid requester wins
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && req_valid[ID_BITS'(idx)]) begin
        gnt     = ID_BITS'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  // Output-register FSM next state and accept decision
  always_comb begin
    state_d    = state_q;
    can_accept = (state_q == EMPTY) || resp_ready;
    accept     = gnt_vld && can_accept && rst_n;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (resp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // One-hot ready to the granted requester, held low during reset
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end

  assign shift_res  = do_shift(op_data[gnt], op_shamt[gnt], op_code[gnt]);
  assign resp_valid = (state_q == FULL);

  // Output-register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Response payload and round-robin pointer; both advance only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
      resp_id   <= '0;
      ptr_q     <= '0;
    end else if (accept) begin
      resp_data <= shift_res;
      resp_id   <= gnt;
      ptr_q     <= (gnt == ID_BITS'(NUM_REQ - 1)) ? '0 : gnt + ID_BITS'(1);
    end
  end

`ifdef DL_SHIFT_ARB_STALL_CNT_EN
  // Count cycles where a held response is refused, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (resp_valid && !resp_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dl_shift_arb.md
Name: dl_shift_arb

Overview:
- Round-robin arbiter and sequencer that shares one barrel shifter among NUM_REQ requesters.
- The shifter supports SLL, SRL, SRA and ROR.
- Each requester uses a valid/ready handshake. Results return through a single registered response port, tagged with the requester index.
- Sits between the ALU/CSR/address-gen clients and the shared shift datapath in the integer pipeline.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- NUM_BITS, 32, operand width; must be a power of 2.
- ID_BITS, $clog2(NUM_REQ), localparam, response tag width.
- SH_BITS, $clog2(NUM_BITS), localparam, shift amount width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*NUM_BITS  operands, packed; requester i at [i*NUM_BITS +: NUM_BITS].
- req_shamt  in  NUM_REQ*SH_BITS  shift amounts, packed the same way.
- req_op  in  NUM_REQ*2  opcodes, packed: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  NUM_BITS  shifted result.
- resp_id  out  ID_BITS  index of the requester that produced resp_data.
- stall_cnt  out  16  present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_data=0, resp_id=0, RR pointer=0, stall_cnt=0. req_ready=0 while in reset.
- Output register states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- can_accept = !resp_valid | resp_ready (combinational).
- Arbitration (combinational):
  - Scan indices ptr, ptr+1, ..., ptr+NUM_REQ-1 mod NUM_REQ.
  - The first asserted req_valid is granted.
  - req_ready[g] = can_accept & req_valid[g]; all other req_ready bits are 0.
- Handshake on a cycle with req_valid[g] & req_ready[g]:
  - Next edge: resp_data = shift(req_data[g], req_shamt[g], req_op[g]); resp_id = g; resp_valid = 1; ptr = (g+1) mod NUM_REQ.
  - Latency is 1 cycle from accept to resp_valid.
- No accept while can_accept is low: ptr and the response register hold. If resp_ready is also low, the FULL register holds unchanged.
- FULL & resp_ready & no new accept: resp_valid -> 0. resp_data and resp_id hold their stale values.
- FULL & resp_ready & new accept in the same cycle: the register reloads with the new result and resp_valid stays 1. Sustained throughput is 1 result per cycle.
- Requester rules:
  - After asserting req_valid, the requester holds it and its operands stable until req_ready.
  - Grant never depends on req_ready being sampled.
- Shift semantics:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with req_data MSB.
  - ROR: rotate right.
  - shamt=0 returns the operand unchanged for all ops.
  - The shift amount is the full SH_BITS field with no further masking.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- No requests valid: ptr holds and req_ready=0.
- Pointer wrap: a grant to NUM_REQ-1 sets ptr to 0.
- Reset mid-operation: a pending response is discarded and not replayed. Requesters must re-present their requests after reset.

Optional Feature:
- Macro: DL_SHIFT_ARB_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments on every cycle with resp_valid & !resp_ready.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: stall_cnt port and its counter are absent; all other behaviour is identical.

Test Plan:
- Single request SRA: req 2 valid, data 32'h8000_00F0, shamt 4, op 10, resp_ready=1 -> req_ready[2]=1 for 1 cycle; next cycle resp_valid=1, resp_data=32'hF800_000F, resp_id=2.
- Round-robin with all 4 valid and resp_ready=1 held high -> grant order 0,1,2,3,0; one response per cycle; resp_id sequence 0,1,2,3,0.
- Backpressure: resp_ready=0 for 3 cycles with req 1 valid (SLL 32'h1 by 31) -> resp_valid holds 1 with resp_data=32'h8000_0000; req_ready stays 0 for other requests; on resp_ready=1 the next request is accepted in the same cycle.
- Opcode and boundary values:
  - ROR 32'h0000_0001 by 1 -> 32'h8000_0000.
  - SRL 32'hFFFF_FFFF by 31 -> 32'h1.
  - shamt 0 on each op -> operand unchanged.
- Asynchronous reset while FULL with ptr=3 -> resp_valid, resp_data, resp_id drop to 0 immediately; after release, a request from 0 and 3 together grants 0 first.
- With DL_SHIFT_ARB_STALL_CNT_EN: hold resp_valid=1, resp_ready=0 for 10 cycles -> stall_cnt=10. A forced long stall saturates at 16'hFFFF.
